// File: rtl/risc16_control_unit.sv
// rtl/risc16_control_unit.sv - multi-cycle fetch/decode/execute control FSM and PC owner for the RISC-16 core
//
// Purpose:
//   Sequences every instruction through FETCH -> DECODE -> EXEC -> (MEM) -> WB,
//   drives register-file addresses and write controls, ALU controls and
//   data-memory requests, and owns the program counter.
//
// Build option:
//   RISC16_INSTR_COUNT_EN - when defined, instr_count counts retired
//   instructions (one per WB, wraps at 2^32). When undefined, it is tied to 0.
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   imem_req / imem_ready   instruction fetch handshake; instr_in valid with imem_ready
//   instr_in[15:0]          fetched instruction
//   pc[15:0]                current PC (fetch address, register file pc input)
//   rA, rB, rC[2:0]         register addresses IR[12:10], IR[9:7], IR[2:0]
//   MUX_rf                  1: read port 2 addresses rA, 0: rC
//   MUX_tgt[1:0]            write source 00 mem, 01 alu, 10 pc+1
//   WE_rf                   register file write enable
//   reg_out1, reg_out2      register file read data (1-cycle read latency)
//   imm[15:0]               decoded immediate
//   alu_op[1:0], alu_src    ALU function (00 add, 01 nand, 10 pass-B), B select (1 imm)
//   dmem_re, dmem_we        data memory read / write requests
//   dmem_ready              data memory access complete
//   halted                  core halted (exit only by reset)
//   instr_count[31:0]       retired-instruction counter

module risc16_control_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   input  logic        imem_ready,
   input  logic [15:0] instr_in,
   output logic [15:0] pc,
   output logic [2:0]  rA,
   output logic [2:0]  rB,
   output logic [2:0]  rC,
   output logic        MUX_rf,
   output logic [1:0]  MUX_tgt,
   output logic        WE_rf,
   input  logic [15:0] reg_out1,
   input  logic [15:0] reg_out2,
   output logic [15:0] imm,
   output logic [1:0]  alu_op,
   output logic        alu_src,
   output logic        dmem_re,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        halted,
   output logic [31:0] instr_count
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   localparam logic [1:0] TGT_MEM = 2'b00;
   localparam logic [1:0] TGT_ALU = 2'b01;
   localparam logic [1:0] TGT_PC1 = 2'b10;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_NAND = 2'b01;
   localparam logic [1:0] ALU_PASS = 2'b10;

   // Every control output lives in this one register so the whole set is
   // loaded together on each state transition.
   typedef struct packed {
      logic       imem_req;
      logic       mux_rf;
      logic [1:0] mux_tgt;
      logic       we_rf;
      logic [1:0] alu_op;
      logic       alu_src;
      logic       dmem_re;
      logic       dmem_we;
      logic       halted;
   } ctl_t;

   state_t      r_state;
   logic [15:0] r_ir;
   logic [15:0] r_pc;
   logic        r_taken;
   ctl_t        r_ctl;

   logic [2:0]  w_op;
   logic        w_is_mem;
   logic        w_is_halt;
   logic [15:0] w_pc_inc;

   assign w_op      = r_ir[15:13];
   assign w_is_mem  = (w_op == OP_LW) || (w_op == OP_SW);
   assign w_is_halt = (w_op == OP_JALR) && (r_ir[6:0] != 7'd0);
   assign w_pc_inc  = r_pc + 16'd1;

   // Control outputs that are valid while the FSM sits in state s with
   // opcode op. Called with the destination state on each transition so the
   // outputs come straight from flops.
   function automatic ctl_t ctl_for(input state_t s, input logic [2:0] op);
      ctl_t c;
      c = '0;
      case (s)
         S_FETCH: c.imem_req = 1'b1;
         S_DECODE: c.mux_rf = (op == OP_SW) || (op == OP_BEQ);
         S_EXEC, S_MEM, S_WB: begin
            // Read addresses and ALU controls stay put through MEM and WB:
            // the store data and the ALU result are consumed there.
            c.mux_rf = (op == OP_SW) || (op == OP_BEQ);
            case (op)
               OP_ADD:               begin c.alu_op = ALU_ADD;  c.alu_src = 1'b0; end
               OP_NAND:              begin c.alu_op = ALU_NAND; c.alu_src = 1'b0; end
               OP_ADDI, OP_LW, OP_SW: begin c.alu_op = ALU_ADD;  c.alu_src = 1'b1; end
               OP_LUI:               begin c.alu_op = ALU_PASS; c.alu_src = 1'b1; end
               default:              begin c.alu_op = ALU_ADD;  c.alu_src = 1'b0; end
            endcase
            if (s == S_MEM) begin
               c.dmem_re = (op == OP_LW);
               c.dmem_we = (op == OP_SW);
            end
            if (s == S_WB) begin
               case (op)
                  OP_ADD, OP_ADDI, OP_NAND, OP_LUI: begin c.we_rf = 1'b1; c.mux_tgt = TGT_ALU; end
                  OP_LW:                            begin c.we_rf = 1'b1; c.mux_tgt = TGT_MEM; end
                  OP_JALR:                          begin c.we_rf = 1'b1; c.mux_tgt = TGT_PC1; end
                  default:                          begin c.we_rf = 1'b0; c.mux_tgt = TGT_MEM; end
               endcase
            end
         end
         S_HALT: c.halted = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
         r_ir    <= 16'h0000;
         r_pc    <= RESET_PC;
         r_taken <= 1'b0;
         r_ctl   <= '0;
      end else begin
         case (r_state)
            S_FETCH: begin
               // Reset leaves the FSM in FETCH with the request low; the
               // first cycle out of reset raises it.
               if (!r_ctl.imem_req) begin
                  r_ctl <= ctl_for(S_FETCH, w_op);
               end else if (imem_ready) begin
                  r_ir    <= instr_in;
                  r_state <= S_DECODE;
                  r_ctl   <= ctl_for(S_DECODE, instr_in[15:13]);
               end
            end
            S_DECODE: begin
               r_state <= S_EXEC;
               r_ctl   <= ctl_for(S_EXEC, w_op);
            end
            S_EXEC: begin
               r_taken <= (reg_out1 == reg_out2);
               if (w_is_mem) begin
                  r_state <= S_MEM;
                  r_ctl   <= ctl_for(S_MEM, w_op);
               end else if (w_is_halt) begin
                  r_state <= S_HALT;
                  r_ctl   <= ctl_for(S_HALT, w_op);
               end else begin
                  r_state <= S_WB;
                  r_ctl   <= ctl_for(S_WB, w_op);
               end
            end
            S_MEM: begin
               if (dmem_ready) begin
                  r_state <= S_WB;
                  r_ctl   <= ctl_for(S_WB, w_op);
               end
            end
            S_WB: begin
               if (w_op == OP_JALR) begin
                  r_pc <= reg_out1;
               end else if ((w_op == OP_BEQ) && r_taken) begin
                  r_pc <= w_pc_inc + imm;
               end else begin
                  r_pc <= w_pc_inc;
               end
               r_state <= S_FETCH;
               r_ctl   <= ctl_for(S_FETCH, w_op);
            end
            S_HALT: begin
               r_state <= S_HALT;
               r_ctl   <= ctl_for(S_HALT, w_op);
            end
            default: begin
               r_state <= S_FETCH;
               r_ctl   <= '0;
            end
         endcase
      end
   end

   always_comb begin
      imm = 16'h0000;
      case (w_op)
         OP_ADDI, OP_SW, OP_LW, OP_BEQ: imm = {{9{r_ir[6]}}, r_ir[6:0]};
         OP_LUI:                        imm = {r_ir[9:0], 6'b000000};
         default:                       imm = 16'h0000;
      endcase
   end

`ifdef RISC16_INSTR_COUNT_EN
   logic [31:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 32'h0000_0000;
      end else if (r_state == S_WB) begin
         r_count <= r_count + 32'd1;
      end
   end

   assign instr_count = r_count;
`else
   assign instr_count = 32'h0000_0000;
`endif

   assign pc       = r_pc;
   assign rA       = r_ir[12:10];
   assign rB       = r_ir[9:7];
   assign rC       = r_ir[2:0];
   assign imem_req = r_ctl.imem_req;
   assign MUX_rf   = r_ctl.mux_rf;
   assign MUX_tgt  = r_ctl.mux_tgt;
   assign WE_rf    = r_ctl.we_rf;
   assign alu_op   = r_ctl.alu_op;
   assign alu_src  = r_ctl.alu_src;
   assign dmem_re  = r_ctl.dmem_re;
   assign dmem_we  = r_ctl.dmem_we;
   assign halted   = r_ctl.halted;

endmodule

// File: tb/tb_risc16_control_unit.sv
// tb/tb_risc16_control_unit.sv - table-driven self-checking bench for risc16_control_unit

module tb_risc16_control_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic        imem_ready;
   logic [15:0] instr_in;
   logic [15:0] pc;
   logic [2:0]  rA, rB, rC;
   logic        MUX_rf;
   logic [1:0]  MUX_tgt;
   logic        WE_rf;
   logic [15:0] reg_out1, reg_out2;
   logic [15:0] imm;
   logic [1:0]  alu_op;
   logic        alu_src;
   logic        dmem_re, dmem_we;
   logic        dmem_ready;
   logic        halted;
   logic [31:0] instr_count;

   int n_vec;
   int n_bad;

   risc16_control_unit #(.RESET_PC(16'h0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_ready(imem_ready), .instr_in(instr_in),
      .pc(pc), .rA(rA), .rB(rB), .rC(rC),
      .MUX_rf(MUX_rf), .MUX_tgt(MUX_tgt), .WE_rf(WE_rf),
      .reg_out1(reg_out1), .reg_out2(reg_out2),
      .imm(imm), .alu_op(alu_op), .alu_src(alu_src),
      .dmem_re(dmem_re), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
      .halted(halted), .instr_count(instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      logic [15:0] ro1;
      logic [15:0] ro2;
      logic [15:0] pc0;
      logic [15:0] pc1;
      logic [15:0] imm;
      logic        chk_alu;
      logic [1:0]  alu_op;
      logic        alu_src;
      logic        mux_rf;
      logic [2:0]  ra;
      logic        we;
      logic [1:0]  tgt;
      logic        mem;
      logic        dre;
      logic        dwe;
      int          mwait;
   } vec_t;

   vec_t vecs[12];
   vec_t v_jump;
   vec_t v_addi;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_fetch(input string tag);
      int n;
      n = 0;
      while (imem_req !== 1'b1 && n < 8) begin
         @(posedge clk);
         @(negedge clk);
         n++;
      end
      chk({tag, ".fetch_req"}, {31'd0, imem_req}, 32'd1);
   endtask

   // Accept the fetch and step to DECODE, checking decode-stage outputs.
   task automatic fetch_decode(input string tag, input logic [15:0] instr, input logic [15:0] exp_pc);
      wait_fetch(tag);
      chk({tag, ".pc0"}, {16'd0, pc}, {16'd0, exp_pc});
      imem_ready = 1'b1;
      instr_in   = instr;
      @(posedge clk);
      @(negedge clk);
      imem_ready = 1'b0;
      chk({tag, ".dec_req"}, {31'd0, imem_req}, 32'd0);
   endtask

   task automatic run_vec(input string tag, input vec_t v);
      fetch_decode(tag, v.instr, v.pc0);
      chk({tag, ".imm"}, {16'd0, imm}, {16'd0, v.imm});
      chk({tag, ".dec_muxrf"}, {31'd0, MUX_rf}, {31'd0, v.mux_rf});
      chk({tag, ".dec_we"}, {31'd0, WE_rf}, 32'd0);
      reg_out1 = v.ro1;
      reg_out2 = v.ro2;
      @(posedge clk);
      @(negedge clk);
      if (v.chk_alu) begin
         chk({tag, ".alu_op"}, {30'd0, alu_op}, {30'd0, v.alu_op});
         chk({tag, ".alu_src"}, {31'd0, alu_src}, {31'd0, v.alu_src});
      end
      chk({tag, ".ex_muxrf"}, {31'd0, MUX_rf}, {31'd0, v.mux_rf});
      chk({tag, ".ex_we_tgt"}, {29'd0, WE_rf, MUX_tgt}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      if (v.mem) begin
         for (int k = 0; k <= v.mwait; k++) begin
            chk($sformatf("%s.mem%0d_re_we", tag, k), {30'd0, dmem_re, dmem_we}, {30'd0, v.dre, v.dwe});
            chk($sformatf("%s.mem%0d_we_rf", tag, k), {31'd0, WE_rf}, 32'd0);
            if (k == v.mwait) dmem_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            dmem_ready = 1'b0;
         end
      end
      chk({tag, ".wb_we"}, {31'd0, WE_rf}, {31'd0, v.we});
      chk({tag, ".wb_tgt"}, {30'd0, MUX_tgt}, {30'd0, v.tgt});
      chk({tag, ".wb_rA"}, {29'd0, rA}, {29'd0, v.ra});
      chk({tag, ".wb_dmem"}, {30'd0, dmem_re, dmem_we}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk({tag, ".pc1"}, {16'd0, pc}, {16'd0, v.pc1});
      chk({tag, ".next_fetch"}, {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      logic [31:0] exp_cnt12;
      logic [31:0] exp_cnt1;
      logic [15:0] frozen_pc;
`ifdef RISC16_INSTR_COUNT_EN
      exp_cnt12 = 32'd12;
      exp_cnt1  = 32'd1;
`else
      exp_cnt12 = 32'd0;
      exp_cnt1  = 32'd0;
`endif
      n_vec = 0;
      n_bad = 0;
      rst_n = 1'b0;
      imem_ready = 1'b0;
      instr_in = 16'h0000;
      reg_out1 = 16'h0000;
      reg_out2 = 16'h0000;
      dmem_ready = 1'b0;

      //        instr     ro1       ro2       pc0       pc1       imm       ca  aop  as   mrf  ra    we   tgt   mem  dre  dwe  wait
      vecs[0]  = '{16'h2405, 16'h0000, 16'h0000, 16'h0000, 16'h0001, 16'h0005, 1, 2'd0, 1'b1, 1'b0, 3'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 0};
      vecs[1]  = '{16'h6BFF, 16'h0000, 16'h0000, 16'h0001, 16'h0002, 16'hFFC0, 1, 2'd2, 1'b1, 1'b0, 3'd2, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 0};
      vecs[2]  = '{16'h0503, 16'h0007, 16'h0008, 16'h0002, 16'h0003, 16'h0000, 1, 2'd0, 1'b0, 1'b0, 3'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 0};
      vecs[3]  = '{16'h5286, 16'h0007, 16'h0008, 16'h0003, 16'h0004, 16'h0000, 1, 2'd1, 1'b0, 1'b0, 3'd4, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 0};
      vecs[4]  = '{16'h8402, 16'h0005, 16'h0006, 16'h0004, 16'h0005, 16'h0002, 1, 2'd0, 1'b1, 1'b1, 3'd1, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 3};
      vecs[5]  = '{16'hAC02, 16'h0005, 16'h0006, 16'h0005, 16'h0006, 16'h0002, 1, 2'd0, 1'b1, 1'b0, 3'd3, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 3};
      vecs[6]  = '{16'hAC02, 16'h0005, 16'h0006, 16'h0006, 16'h0007, 16'h0002, 1, 2'd0, 1'b1, 1'b0, 3'd3, 1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 0};
      vecs[7]  = '{16'hFD00, 16'h0010, 16'h0000, 16'h0007, 16'h0010, 16'h0000, 0, 2'd0, 1'b0, 1'b0, 3'd7, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 0};
      vecs[8]  = '{16'hC4FE, 16'h0055, 16'h0055, 16'h0010, 16'h000F, 16'hFFFE, 0, 2'd0, 1'b0, 1'b1, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0};
      vecs[9]  = '{16'hC4FE, 16'h0001, 16'h0002, 16'h000F, 16'h0010, 16'hFFFE, 0, 2'd0, 1'b0, 1'b1, 3'd1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 0};
      vecs[10] = '{16'hFD00, 16'hFFFF, 16'h0000, 16'h0010, 16'hFFFF, 16'h0000, 0, 2'd0, 1'b0, 1'b0, 3'd7, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 0};
      vecs[11] = '{16'h2405, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0005, 1, 2'd0, 1'b1, 1'b0, 3'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 0};
      v_jump   = '{16'hFD00, 16'h0040, 16'h0000, 16'h0000, 16'h0040, 16'h0000, 0, 2'd0, 1'b0, 1'b0, 3'd7, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 0};
      v_addi   = vecs[0];

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst.pc", {16'd0, pc}, 32'h0000);
      chk("rst.enables", {27'd0, imem_req, dmem_re, dmem_we, WE_rf, halted}, 32'd0);
      chk("rst.count", instr_count, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 12; i++) begin
         run_vec($sformatf("v%0d", i), vecs[i]);
      end
      chk("count.after12", instr_count, exp_cnt12);

      // JALR r0,r0,1 halts: no retire, pc frozen, no further fetches
      fetch_decode("halt", 16'hE001, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      frozen_pc = pc;
      @(posedge clk);
      @(negedge clk);
      chk("halt.halted", {31'd0, halted}, 32'd1);
      chk("halt.we", {31'd0, WE_rf}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("halt.idle%0d", k), {15'd0, imem_req, pc}, {16'd0, frozen_pc});
         @(posedge clk);
         @(negedge clk);
      end
      chk("halt.pc", {16'd0, pc}, 32'h0000);
      chk("halt.count", instr_count, exp_cnt12);

      rst_n = 1'b0;
      #1;
      chk("halt_rst.halted", {31'd0, halted}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Move pc away from RESET_PC, then reset in the middle of a stalled store
      run_vec("jump40", v_jump);
      fetch_decode("swrst", 16'h8402, 16'h0040);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("swrst.dmem_we", {31'd0, dmem_we}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("swrst.we_drop", {31'd0, dmem_we}, 32'd0);
      chk("swrst.pc", {16'd0, pc}, 32'h0000);
      chk("swrst.req", {31'd0, imem_req}, 32'd0);
      chk("swrst.count", instr_count, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_vec("post_rst", v_addi);
      chk("post_rst.count", instr_count, exp_cnt1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
